irq_controller: RTL and testbench

Interrupt responder paired with the microcode sequencer. It synchronises eight external interrupt lines and latches their rising edges as pending requests. It qualifies them with a mask register and the CPU interrupt-enable bit, and drives the sequencer's `int_pending` condition input. It then completes the sequencer's vector-fetch / acknowledge handshake (`ctrl_int_vector_wrt`, `ctrl_int_ack`, `ctrl_clear_all_ints`, `ctrl_irq_masks_wrt`). The block sits on the CPU board between the peripheral IRQ pins and the sequencer; `int_vector` and `irq_masks` are readable on the data path.

---
 rtl/irq_controller.sv | 112 +++++++++++
 tb/tb_irq_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Interrupt responder for the microcode sequencer: synchronises IRQ lines, latches
// rising edges as pending requests and runs the vector-fetch / acknowledge handshake.
//
// state     | meaning
// IDLE      | no request in service; int_pending may assert
// SERVICING | vector latched, waiting for ctrl_int_ack
module irq_controller #(
    parameter int          NBR_IRQS        = 8,
    parameter logic [7:0]  SPURIOUS_VECTOR = 8'h10
) (
    input  logic                clk,
    input  logic                arst,
    input  logic [NBR_IRQS-1:0] irq_in,
    input  logic                irq_en,
    input  logic [7:0]          z_bus,
    input  logic                ctrl_irq_masks_wrt,
    input  logic                ctrl_int_vector_wrt,
    input  logic                ctrl_int_ack,
    input  logic                ctrl_clear_all_ints,
    output logic                int_pending,
    output logic [7:0]          int_vector,
    output logic [NBR_IRQS-1:0] irq_masks,
    output logic [NBR_IRQS-1:0] irq_status,
    output logic                in_service
);

    typedef enum logic {IDLE, SERVICING} state_t;

    state_t              state, state_next;
    logic [NBR_IRQS-1:0] s1, s2, s3;
    logic [NBR_IRQS-1:0] pending;
    logic [NBR_IRQS-1:0] rise;
    logic [NBR_IRQS-1:0] req;
    logic [NBR_IRQS-1:0] ack_mask;
    logic [2:0]          idx;
    logic [2:0]          active_idx;
    logic [7:0]          vector_next;
    logic                load_vector;
    logic                ack_clear;

    assign rise = s2 & ~s3;
    assign req  = pending & irq_masks;

    // Lowest index wins: scan downwards so the last hit is the lowest set bit.
    always_comb begin
        idx = '0;
        for (int i = NBR_IRQS - 1; i >= 0; i--) begin
            if (req[i]) idx = i[2:0];
        end
    end

    assign vector_next = (req != '0) ? {4'b0000, idx, 1'b0} : SPURIOUS_VECTOR;
    assign ack_mask    = {{(NBR_IRQS-1){1'b0}}, 1'b1} << active_idx;

    always_comb begin
        state_next  = state;
        load_vector = 1'b0;
        ack_clear   = 1'b0;
        case (state)
            IDLE: begin
                if (!ctrl_int_vector_wrt) begin
                    load_vector = 1'b1;
                    if (req != '0) state_next = SERVICING;
                end
            end
            SERVICING: begin
                if (ctrl_int_ack) begin
                    ack_clear  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Clear-all overrides the transition but the vector still latches pre-clear req.
        if (ctrl_clear_all_ints) state_next = IDLE;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state      <= IDLE;
            s1         <= '0;
            s2         <= '0;
            s3         <= '0;
            pending    <= '0;
            irq_masks  <= '0;
            int_vector <= '0;
            active_idx <= '0;
        end else begin
            state <= state_next;
            s1    <= irq_in;
            s2    <= s1;
            s3    <= s2;
            if (ctrl_clear_all_ints)
                pending <= '0;
            else if (ack_clear)
                pending <= (pending & ~ack_mask) | rise;
            else
                pending <= pending | rise;
            if (!ctrl_irq_masks_wrt)
                irq_masks <= z_bus;
            if (load_vector) begin
                int_vector <= vector_next;
                if (req != '0) active_idx <= idx;
            end
        end
    end

    assign int_pending = irq_en & (req != '0) & (state == IDLE);
    assign in_service  = (state == SERVICING);
    assign irq_status  = pending;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: expected values are queued with each stimulus
// step and popped when the corresponding output is sampled.
module tb_irq_controller;

    logic       clk = 1'b0;
    logic       arst;
    logic [7:0] irq_in;
    logic       irq_en;
    logic [7:0] z_bus;
    logic       ctrl_irq_masks_wrt;
    logic       ctrl_int_vector_wrt;
    logic       ctrl_int_ack;
    logic       ctrl_clear_all_ints;
    logic       int_pending;
    logic [7:0] int_vector;
    logic [7:0] irq_masks;
    logic [7:0] irq_status;
    logic       in_service;

    logic [7:0] exp_q[$];
    int         n_pass  = 0;
    int         n_total = 0;

    irq_controller dut (
        .clk                 (clk),
        .arst                (arst),
        .irq_in              (irq_in),
        .irq_en              (irq_en),
        .z_bus               (z_bus),
        .ctrl_irq_masks_wrt  (ctrl_irq_masks_wrt),
        .ctrl_int_vector_wrt (ctrl_int_vector_wrt),
        .ctrl_int_ack        (ctrl_int_ack),
        .ctrl_clear_all_ints (ctrl_clear_all_ints),
        .int_pending         (int_pending),
        .int_vector          (int_vector),
        .irq_masks           (irq_masks),
        .irq_status          (irq_status),
        .in_service          (in_service)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs);
        logic [7:0] exp_v;
        n_total++;
        if (exp_q.size() == 0) begin
            $error("FAIL %s: observed %h, required value missing from queue", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) n_pass++;
            else $error("FAIL %s: observed %h required %h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_int(input string tag, input int budget);
        for (int i = 0; i < budget && !int_pending; i++) step();
        push(8'h01);
        chk(tag, {7'b0, int_pending});
    endtask

    task automatic write_mask(input logic [7:0] m);
        z_bus = m;
        ctrl_irq_masks_wrt = 1'b0;
        step();
        ctrl_irq_masks_wrt = 1'b1;
    endtask

    task automatic vec_write();
        ctrl_int_vector_wrt = 1'b0;
        step();
        ctrl_int_vector_wrt = 1'b1;
    endtask

    task automatic ack();
        ctrl_int_ack = 1'b1;
        step();
        ctrl_int_ack = 1'b0;
    endtask

    initial begin
        logic saw_int;
        arst = 1'b1; irq_in = '0; irq_en = 1'b0; z_bus = '0;
        ctrl_irq_masks_wrt = 1'b1; ctrl_int_vector_wrt = 1'b1;
        ctrl_int_ack = 1'b0; ctrl_clear_all_ints = 1'b0;
        #23;
        push(8'h00); chk("rst_vector", int_vector);
        push(8'h00); chk("rst_masks", irq_masks);
        push(8'h00); chk("rst_status", irq_status);
        push(8'h00); chk("rst_flags", {6'b0, in_service, int_pending});
        arst = 1'b0;
        irq_en = 1'b1;
        saw_int = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            saw_int = saw_int | int_pending;
        end
        push(8'h00); chk("rst_quiet", {7'b0, saw_int});

        // Single request on line 3
        write_mask(8'h08);
        push(8'h08); chk("mask_08", irq_masks);
        irq_in = 8'h08;
        step();
        push(8'h00); chk("lat_edge_k", {7'b0, int_pending});
        step();
        push(8'h00); chk("lat_edge_k1", {7'b0, int_pending});
        step();
        push(8'h01); chk("lat_edge_k2", {7'b0, int_pending});
        irq_in = 8'h00;
        vec_write();
        push(8'h06); chk("vec_line3", int_vector);
        push(8'h02); chk("svc_flags", {6'b0, in_service, int_pending});
        ack();
        push(8'h00); chk("ack_status", irq_status);
        push(8'h00); chk("ack_idle", {7'b0, in_service});

        // Priority with masking
        write_mask(8'h60);
        irq_in = 8'h62;
        wait_int("prio_wait", 6);
        irq_in = 8'h00;
        push(8'h62); chk("prio_status", irq_status);
        vec_write();
        push(8'h0A); chk("prio_vec5", int_vector);
        ack();
        push(8'h42); chk("prio_status_after_ack", irq_status);
        push(8'h01); chk("prio_int_again", {7'b0, int_pending});
        vec_write();
        push(8'h0C); chk("prio_vec6", int_vector);
        ack();
        push(8'h02); chk("prio_status_end", irq_status);

        // Spurious vector write (only masked-out bit 1 pending)
        vec_write();
        push(8'h10); chk("spur_vec", int_vector);
        push(8'h00); chk("spur_flags", {6'b0, in_service, int_pending});

        // Rise on line 3 on the same edge as its ack
        write_mask(8'h08);
        irq_in = 8'h08;
        wait_int("coll_wait", 6);
        irq_in = 8'h00;
        vec_write();
        push(8'h01); chk("coll_svc", {7'b0, in_service});
        step(); step(); step();
        irq_in = 8'h08;
        step(); step();
        ack();
        push(8'h0A); chk("coll_status", irq_status);
        push(8'h01); chk("coll_reassert", {6'b0, in_service, int_pending});

        // Clear-all on the same edge as a rise
        ctrl_clear_all_ints = 1'b1;
        step();
        ctrl_clear_all_ints = 1'b0;
        push(8'h00); chk("clear_status", irq_status);
        irq_in = 8'h00;
        step(); step(); step();
        irq_in = 8'h08;
        step(); step();
        ctrl_clear_all_ints = 1'b1;
        step();
        ctrl_clear_all_ints = 1'b0;
        step(); step(); step();
        push(8'h00); chk("clear_rise_lost", irq_status);
        push(8'h06); chk("clear_vec_hold", int_vector);

        // Reset mid-service with three pending bits
        irq_in = 8'h00;
        write_mask(8'hFF);
        step(); step();
        irq_in = 8'h0E;
        wait_int("mid_wait", 6);
        push(8'h0E); chk("mid_status", irq_status);
        vec_write();
        push(8'h02); chk("mid_vec", int_vector);
        push(8'h01); chk("mid_svc", {7'b0, in_service});
        irq_in = 8'h00;
        #2;
        arst = 1'b1;
        #1;
        push(8'h00); chk("arst_vector", int_vector);
        push(8'h00); chk("arst_masks", irq_masks);
        push(8'h00); chk("arst_status", irq_status);
        push(8'h00); chk("arst_flags", {6'b0, in_service, int_pending});
        #10;
        arst = 1'b0;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
